// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel edge detector.
package sobel_pkg;

    // FILL primes the line buffer, RUN streams, DRAIN flushes the trailing border centers.
    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    // Gradients need 3 bits over the pixel width: 4*max per side, signed difference.
    localparam int GRAD_EXTRA = 3;
    localparam int MAG_SAT    = 255;

    function automatic int grad_width(input int dw);
        return dw + GRAD_EXTRA;
    endfunction

endpackage

// File: rtl/sobel_window.sv
// Two-line-plus-two-pixel shift register exposing the 3x3 window taps.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH = 720,
    parameter int DWIDTH    = 8
) (
    input  logic              clock,
    input  logic              i_shift,
    input  logic [DWIDTH-1:0] i_pix,
    output logic [DWIDTH-1:0] o_p00,
    output logic [DWIDTH-1:0] o_p01,
    output logic [DWIDTH-1:0] o_p02,
    output logic [DWIDTH-1:0] o_p10,
    output logic [DWIDTH-1:0] o_p11,
    output logic [DWIDTH-1:0] o_p12,
    output logic [DWIDTH-1:0] o_p20,
    output logic [DWIDTH-1:0] o_p21,
    output logic [DWIDTH-1:0] o_p22
);
    localparam int SR_LEN = 2*IMG_WIDTH + 2;

    // r_sr[k] holds the pixel popped k+1 pops ago; no reset, stale data only reaches border outputs.
    logic [SR_LEN-1:0][DWIDTH-1:0] r_sr;

    // Shift one pixel in on every pop.
    always_ff @(posedge clock) begin
        if (i_shift) r_sr <= {r_sr[SR_LEN-2:0], i_pix};
    end

    // The newest pixel is the bottom-right tap, taken straight from the FIFO head.
    assign o_p22 = i_pix;
    assign o_p21 = r_sr[0];
    assign o_p20 = r_sr[1];
    assign o_p12 = r_sr[IMG_WIDTH-1];
    assign o_p11 = r_sr[IMG_WIDTH];
    assign o_p10 = r_sr[IMG_WIDTH+1];
    assign o_p02 = r_sr[2*IMG_WIDTH-1];
    assign o_p01 = r_sr[2*IMG_WIDTH];
    assign o_p00 = r_sr[2*IMG_WIDTH+1];

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge magnitude, FIFO in / FIFO out, one pixel per cycle.
module sobel_filter
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in_dout,
    input  logic              in_empty,
    output logic              in_rd_en,
    output logic [DWIDTH-1:0] out_din,
    input  logic              out_full,
    output logic              out_wr_en
);
    localparam int GW = grad_width(DWIDTH);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 2);

    state_t          r_state, w_next;
    logic [CW-1:0]   r_ccol;
    logic [RW-1:0]   r_crow;
    logic [FW-1:0]   r_fill;

    logic [DWIDTH-1:0] w_p00, w_p01, w_p02, w_p10, w_p11_unused, w_p12, w_p20, w_p21, w_p22;

    sobel_window #(.IMG_WIDTH(IMG_WIDTH), .DWIDTH(DWIDTH)) u_window (
        .clock   (clock),
        .i_shift (in_rd_en),
        .i_pix   (in_dout),
        .o_p00   (w_p00),
        .o_p01   (w_p01),
        .o_p02   (w_p02),
        .o_p10   (w_p10),
        .o_p11   (w_p11_unused),
        .o_p12   (w_p12),
        .o_p20   (w_p20),
        .o_p21   (w_p21),
        .o_p22   (w_p22)
    );

    // a + 2b + c, zero-extended to gradient width.
    function automatic logic [GW-1:0] wsum(input logic [DWIDTH-1:0] a, b, c);
        return GW'(a) + (GW'(b) << 1) + GW'(c);
    endfunction

    logic [GW-1:0]     w_gx, w_gy, w_ax, w_ay, w_mag;
    logic [DWIDTH-1:0] w_sat;
    logic              w_border, w_col_end, w_row_end, w_run_last, w_hs;

    // Two's-complement differences; |G| <= 1020 so the sum of magnitudes fits GW unsigned bits.
    assign w_gx  = wsum(w_p02, w_p12, w_p22) - wsum(w_p00, w_p10, w_p20);
    assign w_gy  = wsum(w_p20, w_p21, w_p22) - wsum(w_p00, w_p01, w_p02);
    assign w_ax  = w_gx[GW-1] ? -w_gx : w_gx;
    assign w_ay  = w_gy[GW-1] ? -w_gy : w_gy;
    assign w_mag = (w_ax + w_ay) >> 1;
    assign w_sat = (w_mag > GW'(MAG_SAT)) ? DWIDTH'(MAG_SAT) : w_mag[DWIDTH-1:0];

    assign w_col_end  = (r_ccol == CW'(IMG_WIDTH-1));
    assign w_row_end  = (r_crow == RW'(IMG_HEIGHT-1));
    assign w_border   = (r_crow == '0) || w_row_end || (r_ccol == '0) || w_col_end;
    // Center W*H-W-2 pairs with the last input pixel of the frame.
    assign w_run_last = (r_crow == RW'(IMG_HEIGHT-2)) && (r_ccol == CW'(IMG_WIDTH-2));
    assign w_hs       = !in_empty && !out_full;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= FILL;
        else        r_state <= w_next;
    end

    // Next state and zero-latency FIFO handshakes; all outputs forced low during reset.
    always_comb begin
        w_next    = r_state;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        out_din   = '0;
        if (reset) begin
            case (r_state)
                FILL: begin
                    in_rd_en = !in_empty;
                    if (!in_empty && r_fill == FW'(IMG_WIDTH)) w_next = RUN;
                end
                RUN: begin
                    in_rd_en  = w_hs;
                    out_wr_en = w_hs;
                    if (w_hs) begin
                        out_din = w_border ? '0 : w_sat;
                        if (w_run_last) w_next = DRAIN;
                    end
                end
                DRAIN: begin
                    out_wr_en = !out_full;
                    if (!out_full && w_col_end && w_row_end) w_next = FILL;
                end
                default: w_next = FILL;
            endcase
        end
    end

    // Fill-pop counter and center row/column tracking; the center advances on every push.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fill <= '0;
            r_ccol <= '0;
            r_crow <= '0;
        end else begin
            if (r_state == FILL && in_rd_en)
                r_fill <= (r_fill == FW'(IMG_WIDTH)) ? '0 : r_fill + FW'(1);
            if (out_wr_en) begin
                if (w_col_end) begin
                    r_ccol <= '0;
                    r_crow <= w_row_end ? '0 : r_crow + RW'(1);
                end else begin
                    r_ccol <= r_ccol + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench: 4x4 and 5x5 instances, golden frames from a direct 3x3 convolution.
module tb_sobel_filter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_dout   [2];
    logic       in_empty  [2];
    logic       in_rd_en  [2];
    logic       out_full  [2];
    logic       out_wr_en [2];
    logic [7:0] out_din   [2];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [2][$];
    int         push_cnt [2];
    int         rd_cnt   [2];
    bit         full_own [2];
    int         empty_pct = 0;
    int         full_pct  = 0;
    logic [7:0] img [25];

    sobel_filter #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DWIDTH(8)) u_dut0 (
        .clock(clock), .reset(reset),
        .in_dout(in_dout[0]), .in_empty(in_empty[0]), .in_rd_en(in_rd_en[0]),
        .out_din(out_din[0]), .out_full(out_full[0]), .out_wr_en(out_wr_en[0]));

    sobel_filter #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .DWIDTH(8)) u_dut1 (
        .clock(clock), .reset(reset),
        .in_dout(in_dout[1]), .in_empty(in_empty[1]), .in_rd_en(in_rd_en[1]),
        .out_din(out_din[1]), .out_full(out_full[1]), .out_wr_en(out_wr_en[1]));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Golden: 3x3 Sobel kernels applied directly to the 2D image, borders zero.
    task automatic push_golden(input int k, input int w, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            int r, c, gx, gy, mag;
            r = i / w;
            c = i % w;
            mag = 0;
            if (r != 0 && r != h-1 && c != 0 && c != w-1) begin
                gx = 0;
                gy = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        int p;
                        p = int'(img[(r+dr)*w + (c+dc)]);
                        gx += dc * ((dr == 0) ? 2 : 1) * p;
                        gy += dr * ((dc == 0) ? 2 : 1) * p;
                    end
                mag = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) / 2;
                if (mag > 255) mag = 255;
            end
            exp_q[k].push_back(8'(mag));
        end
    endtask

    // Monitor: sample just before each rising edge and score every push.
    always @(negedge clock) begin
        #4;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_while_empty dut%0d", k), 32'(in_rd_en[k] & in_empty[k]), 0);
            if (in_rd_en[k] && !in_empty[k]) rd_cnt[k]++;
            if (out_wr_en[k] === 1'b1) begin
                check($sformatf("wr_while_full dut%0d", k), 32'(out_full[k]), 0);
                if (exp_q[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push dut%0d: got %0d expected no push", k, out_din[k]);
                end else begin
                    check($sformatf("pixel dut%0d push%0d", k, push_cnt[k]), 32'(out_din[k]),
                          32'(exp_q[k].pop_front()));
                end
                push_cnt[k]++;
            end else begin
                check($sformatf("din_idle dut%0d", k), 32'(out_din[k]), 0);
            end
        end
    end

    // Downstream backpressure, unless a directed stall owns the line.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++)
            if (!full_own[k]) out_full[k] = ($urandom_range(0, 99) < full_pct);
    end

    task automatic send(input int k, input int n, input int stall_at);
        int idx, budget;
        idx = 0;
        budget = 0;
        while (idx < n && budget < 5000) begin
            @(negedge clock);
            budget++;
            in_empty[k] = ($urandom_range(0, 99) < empty_pct);
            in_dout[k]  = img[idx];
            #4;
            if (in_rd_en[k] && !in_empty[k]) begin
                idx++;
                if (idx == stall_at) begin
                    full_own[k] = 1'b1;
                    repeat (5) begin
                        @(negedge clock);
                        out_full[k] = 1'b1;
                        in_empty[k] = 1'b0;
                        in_dout[k]  = img[idx];
                        #4;
                        check("stall_rd_en", 32'(in_rd_en[k]), 0);
                        check("stall_wr_en", 32'(out_wr_en[k]), 0);
                    end
                    full_own[k] = 1'b0;
                end
            end
        end
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: got %0d pops expected %0d", k, idx, n);
        end
    endtask

    task automatic wait_idle(input int k, output int drained);
        int snap, budget;
        @(negedge clock);
        in_empty[k] = 1'b1;
        snap = push_cnt[k];
        budget = 0;
        while (exp_q[k].size() != 0 && budget < 500) begin
            @(negedge clock);
            budget++;
        end
        if (exp_q[k].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", k, exp_q[k].size());
            exp_q[k].delete();
        end
        repeat (4) @(negedge clock);
        drained = push_cnt[k] - snap;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            full_own[k] = 1'b1;
            out_full[k] = 1'b0;
            in_empty[k] = 1'b0;
        end
        for (int i = 0; i < cycles; i++) begin
            #4;
            for (int k = 0; k < 2; k++) begin
                check($sformatf("reset_rd_en dut%0d", k), 32'(in_rd_en[k]), 0);
                check($sformatf("reset_wr_en dut%0d", k), 32'(out_wr_en[k]), 0);
                check($sformatf("reset_din dut%0d", k), 32'(out_din[k]), 0);
            end
            @(negedge clock);
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_empty[k] = 1'b1;
            full_own[k] = 1'b0;
        end
    endtask

    task automatic fill_img(input int w, input int h, input int mode);
        for (int i = 0; i < w*h; i++) begin
            case (mode)
                0:       img[i] = 8'd100;
                1:       img[i] = ((i % w) < 2) ? 8'd0 : 8'd255;
                2:       img[i] = (i == 2*w + 2) ? 8'd8 : 8'd0;
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    initial begin
        int p0, r0, drained;
        for (int k = 0; k < 2; k++) begin
            in_empty[k] = 1'b1;
            in_dout[k]  = '0;
            out_full[k] = 1'b0;
            full_own[k] = 1'b0;
            push_cnt[k] = 0;
            rd_cnt[k]   = 0;
        end
        do_reset(3);

        // Flat image: all-zero output, W+1 pushes after the last pop.
        fill_img(4, 4, 0);
        push_golden(0, 4, 4, 16);
        p0 = push_cnt[0];
        r0 = rd_cnt[0];
        send(0, 16, -1);
        wait_idle(0, drained);
        check("flat_drain_pushes", drained, 5);
        check("flat_pushes", push_cnt[0] - p0, 16);
        check("flat_pops", rd_cnt[0] - r0, 16);

        // Vertical edge, unstalled then with a 5-cycle mid-RUN stall.
        fill_img(4, 4, 1);
        push_golden(0, 4, 4, 16);
        p0 = push_cnt[0];
        send(0, 16, -1);
        wait_idle(0, drained);
        check("vedge_pushes", push_cnt[0] - p0, 16);
        push_golden(0, 4, 4, 16);
        p0 = push_cnt[0];
        send(0, 16, 8);
        wait_idle(0, drained);
        check("vedge_stall_pushes", push_cnt[0] - p0, 16);

        // 5x5 single bright pixel.
        fill_img(5, 5, 2);
        push_golden(1, 5, 5, 25);
        p0 = push_cnt[1];
        send(1, 25, -1);
        wait_idle(1, drained);
        check("impulse_pushes", push_cnt[1] - p0, 25);

        // Random images with input gaps and output backpressure, back-to-back pairs.
        empty_pct = 30;
        full_pct  = 30;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 2; k++) begin
                int w;
                w = (k == 0) ? 4 : 5;
                p0 = push_cnt[k];
                fill_img(w, w, 3);
                push_golden(k, w, w, w*w);
                send(k, w*w, -1);
                fill_img(w, w, 3);
                push_golden(k, w, w, w*w);
                send(k, w*w, -1);
                wait_idle(k, drained);
                check($sformatf("rand_pushes dut%0d frame%0d", k, f), push_cnt[k] - p0, 2*w*w);
            end
        end

        // Reset after 7 pops abandons the frame; two clean frames follow back to back.
        empty_pct = 0;
        full_pct  = 0;
        fill_img(4, 4, 1);
        push_golden(0, 4, 4, 2);
        send(0, 7, -1);
        do_reset(1);
        check("queue_after_reset", exp_q[0].size(), 0);
        p0 = push_cnt[0];
        push_golden(0, 4, 4, 16);
        push_golden(0, 4, 4, 16);
        send(0, 16, -1);
        send(0, 16, -1);
        wait_idle(0, drained);
        check("post_reset_pushes", push_cnt[0] - p0, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_filter.md
# sobel_filter

Streaming 3x3 Sobel edge detector placed directly downstream of the grayscale stage. It pops 8-bit grayscale pixels from a first-word-fall-through FIFO in raster order and pushes one 8-bit edge-magnitude pixel per input pixel into an output FIFO. Each output frame is exactly IMG_WIDTH*IMG_HEIGHT pixels. Border pixels are forced to 0, and frames may arrive back to back.

## Interface
- IMG_WIDTH, 720, pixels per row (≥3)
- IMG_HEIGHT, 540, rows per frame (≥3)
- DWIDTH, 8, pixel width (grayscale)

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- in_dout  in  DWIDTH  head-of-FIFO grayscale pixel, valid while in_empty=0
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pop upstream FIFO this cycle
- out_din  out  DWIDTH  edge magnitude, valid when out_wr_en=1
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  push out_din this cycle

## Operation
- Shift register sr of 2*IMG_WIDTH+2 pixels. It shifts in in_dout on every pop.
- Window taps (pNM, N=row, M=col):
  - p22 = in_dout, p21 = sr[0], p20 = sr[1]
  - p12 = sr[W-1], p11 = sr[W], p10 = sr[W+1]
  - p02 = sr[2W-1], p01 = sr[2W], p00 = sr[2W+1]
- The window center is the pixel popped W+1 pops earlier. Counters crow/ccol track the center position.
- Gx = (p02+2p12+p22) − (p00+2p10+p20)
- Gy = (p20+2p21+p22) − (p00+2p01+p02)
- Arithmetic: 11-bit signed, range ±1020. mag = (|Gx|+|Gy|)>>1, 10 bits, saturated to 255.
- out_din = 0 when crow∈{0,H-1} or ccol∈{0,W-1}; otherwise out_din = mag.
- State machine:
  - FILL: in_rd_en = !in_empty. No output. After W+1 pops, go to RUN.
  - RUN: in_rd_en = out_wr_en = !in_empty && !out_full. Each handshake pops one pixel and pushes one. After pushing center index W*H−W−2 (i.e. the final input pixel is consumed), go to DRAIN.
  - DRAIN: in_rd_en = 0. out_wr_en = !out_full, out_din = 0. Pushes the remaining W+1 centers, which are all border. Then go to FILL with counters cleared; the next frame starts.
- Counters: ccol wraps at W−1 → 0 and increments crow. crow wraps at H−1 → 0 at frame end.

## Timing
- Zero-latency handshake: in_rd_en and out_wr_en are combinational from the registered state/counters and the current in_empty/out_full/in_dout. The push happens in the same cycle as the pop (RUN).
- Throughput: 1 pixel/cycle when unstalled. A frame takes W*H + W+1 active cycles.
- While reset=0 (sampled), and combinationally during reset: in_rd_en=0, out_wr_en=0, out_din=0.
- On the next edge, state=FILL and all counters=0. sr contents are not cleared; they are never used for a non-border output before being refilled.
- Reset mid-frame: the partial frame is abandoned and no further pushes occur. Upstream must also restart the frame at pixel 0.
- out_full=1 in RUN stalls both sides. in_empty=1 in RUN stalls both sides. Nothing is lost or duplicated.
- out_full is ignored in FILL.
- out_din is 0 whenever out_wr_en=0.

## Structure
- sobel_pkg holds:
  - state enum {FILL, RUN, DRAIN}
  - Gx/Gy width constant (DWIDTH+3)
  - saturation constant 255
- One sub-module, sobel_window. It contains the sr shift register with shift enable and exports the nine taps. The FSM, counters and gradient arithmetic stay in sobel_filter.

## Test plan (W=4, H=4 unless stated)
- Flat image, all 100 → 16 pushes, all 0. in_rd_en count 16. DRAIN issues 5 pushes.
- Vertical edge, cols 0–1 = 0 and cols 2–3 = 255 → rows 1 and 2 output 0,255,255,0. Rows 0 and 3 are all 0.
- W=H=5, single pixel 8 at (2,2), rest 0:
  - (1,1)=8, (1,2)=8, (2,2)=0, (3,3)=8
  - borders 0, 25 pushes total
- Vertical-edge image with out_full held 1 for 5 cycles mid-RUN → in_rd_en=out_wr_en=0 in those cycles. Output stream is identical to the unstalled run.
- Random in_empty gaps (~30%) plus random out_full → the output sequence equals the golden model. Exactly W*H pushes per frame.
- Reset asserted for 1 cycle after 7 pops, then a full vertical-edge frame → no pushes during reset. Output is exactly the 16-pixel golden frame. A second back-to-back frame also matches.
